// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) doubling helper and the MixColumns FSM state type.
// No timing of its own; used by the column mixer, its interface and the sequencer.
// No flow control here; handshakes live in the interface and the top.
package aes_pkg;

    localparam int         AES_STATE_W = 128;
    localparam int         AES_COL_W   = 32;
    localparam logic [7:0] AES_POLY    = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// State-in / state-out stream bundle for the MixColumns sequencer.
// Carries no timing; both directions are plain valid/ready.
// The producer holds in_* until in_ready; the consumer throttles through out_ready.
interface mix_columns_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   in_bypass;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mix_column_fwd.sv
// Forward MixColumns on a single 32-bit column (byte 0 at the MSB).
// Purely combinational, zero cycles.
// No flow control; the caller decides when the result is used.
module mix_column_fwd
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;

    assign {a0, a1, a2, a3} = col_in;

    // Doubled bytes; tripling is doubling xor the byte itself.
    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);

    assign col_out = {
        d0        ^ (d1 ^ a1) ^ a2        ^ a3,
        a0        ^ d1        ^ (d2 ^ a2) ^ a3,
        a0        ^ a1        ^ d2        ^ (d3 ^ a3),
        (d0 ^ a0) ^ a1        ^ a2        ^ d3
    };

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns: loads a 128-bit state, mixes one column per clock, presents the result.
// Latency 5 cycles from the input handshake when mixing, 1 cycle when bypassing.
// Stalls in DONE while out_ready=0; a new state can enter in the same cycle the old one leaves.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus,
    output logic              busy
);

    localparam int COL_CW = $clog2(NCOL);
    localparam logic [COL_CW-1:0] LAST_COL = COL_CW'(NCOL - 1);

    aes_state_t             state;
    logic [COL_CW-1:0]      col;
    logic [AES_STATE_W-1:0] work;
    logic [AES_COL_W-1:0]   col_cur;
    logic [AES_COL_W-1:0]   col_mixed;
    logic                   in_hs;
    logic                   out_hs;

    // Accept in IDLE, or in DONE when the held result is leaving this very cycle.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = work;
    assign busy          = (state == BUSY);

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    // Select the column being mixed this cycle (column 0 sits at the MSB).
    always_comb begin
        col_cur = work[127:96];
        case (col)
            2'd0:    col_cur = work[127:96];
            2'd1:    col_cur = work[95:64];
            2'd2:    col_cur = work[63:32];
            2'd3:    col_cur = work[31:0];
            default: col_cur = work[127:96];
        endcase
    end

    // One mixer shared across all four column cycles.
    mix_column_fwd u_mix (
        .col_in  (col_cur),
        .col_out (col_mixed)
    );

    // Control FSM and work register; bypass goes straight to DONE with the raw state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        work  <= bus.in_data;
                        col   <= '0;
                        state <= bus.in_bypass ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    case (col)
                        2'd0:    work[127:96] <= col_mixed;
                        2'd1:    work[95:64]  <= col_mixed;
                        2'd2:    work[63:32]  <= col_mixed;
                        2'd3:    work[31:0]   <= col_mixed;
                        default: work[127:96] <= col_mixed;
                    endcase
                    col <= col + 1'b1;
                    if (col == LAST_COL) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        if (in_hs) begin
                            work  <= bus.in_data;
                            col   <= '0;
                            state <= bus.in_bypass ? DONE : BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and round-trip checks for the sequential MixColumns engine.
// Outputs are sampled on the falling edge; inputs change on the falling edge too.
// Back-pressure is exercised by holding out_ready low while a result waits.
module tb_mix_columns_seq;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   failures;

    mix_columns_seq_if bus_if();

    mix_columns_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Launch one state, then wait (bounded) for out_valid; consumes the result if out_ready=1.
    task automatic run(input logic [127:0] din, input logic byp, input bit noise,
                       output logic [127:0] dout, output int lat, output int bcnt);
        @(negedge clk);
        bus_if.in_data   = din;
        bus_if.in_bypass = byp;
        bus_if.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_bypass = 1'b0;
        lat  = 0;
        bcnt = 0;
        dout = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (bus_if.out_valid) begin
                dout = bus_if.out_data;
                bus_if.in_valid = 1'b0;
                break;
            end
            if (noise && busy) begin
                bus_if.in_valid = 1'($urandom_range(0, 1));
                bus_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!bus_if.out_valid) chk("out_valid_timeout", 128'(bus_if.out_valid), 128'd1);
        if (bus_if.out_ready && bus_if.out_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] KC1_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KC1_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KC2_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] KC2_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        logic [127:0] dout;
        logic [127:0] rnd;
        logic [127:0] rec;
        int lat;
        int bcnt;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.in_bypass = 1'b0;
        bus_if.out_ready = 1'b1;
        #22;
        chk("rst_in_ready",  128'(bus_if.in_ready),  128'd1);
        chk("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
        chk("rst_out_data",  bus_if.out_data,        128'd0);
        chk("rst_busy",      128'(busy),             128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // FIPS-197 round 1 column mix.
        run(FIPS_IN, 1'b0, 1'b0, dout, lat, bcnt);
        chk("fips_data",    dout,        FIPS_OUT);
        chk("fips_latency", 128'(lat),   128'd5);
        chk("fips_busy",    128'(bcnt),  128'd4);

        // Known single-column vectors.
        run(KC1_IN, 1'b0, 1'b0, dout, lat, bcnt);
        chk("kc1_data", dout, KC1_OUT);
        run(KC2_IN, 1'b0, 1'b0, dout, lat, bcnt);
        chk("kc2_data", dout, KC2_OUT);

        // Final-round bypass.
        run(BYP_IN, 1'b1, 1'b0, dout, lat, bcnt);
        chk("byp_data",    dout,       BYP_IN);
        chk("byp_latency", 128'(lat),  128'd1);
        chk("byp_busy",    128'(bcnt), 128'd0);

        // Back-pressure: result waits 10 cycles while a new request is pending.
        bus_if.out_ready = 1'b0;
        run(KC1_IN, 1'b0, 1'b0, dout, lat, bcnt);
        chk("bp_first", dout, KC1_OUT);
        bus_if.in_data   = KC2_IN;
        bus_if.in_bypass = 1'b0;
        bus_if.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(bus_if.out_valid), 128'd1);
            chk("bp_out_data",  bus_if.out_data,        KC1_OUT);
            chk("bp_in_ready",  128'(bus_if.in_ready),  128'd0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(bus_if.in_ready), 128'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        chk("b2b_busy", 128'(busy), 128'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus_if.out_valid) break;
        end
        chk("b2b_latency", 128'(lat),       128'd5);
        chk("b2b_data",    bus_if.out_data, KC2_OUT);
        @(posedge clk);
        #1;

        // Asynchronous reset while column 2 is being mixed.
        @(negedge clk);
        bus_if.in_data  = FIPS_IN;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(bus_if.out_valid), 128'd0);
        chk("mid_rst_in_ready",  128'(bus_if.in_ready),  128'd1);
        chk("mid_rst_out_data",  bus_if.out_data,        128'd0);
        chk("mid_rst_busy",      128'(busy),             128'd0);
        #3;
        rst_n = 1'b1;
        run(FIPS_IN, 1'b0, 1'b0, dout, lat, bcnt);
        chk("post_rst_data",    dout,      FIPS_OUT);
        chk("post_rst_latency", 128'(lat), 128'd5);

        // Random round trip through the inverse column transform, with noise on in_valid.
        for (int n = 0; n < 200; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run(rnd, 1'b0, 1'b1, dout, lat, bcnt);
            rec = {inv_col(dout[127:96]), inv_col(dout[95:64]),
                   inv_col(dout[63:32]),  inv_col(dout[31:0])};
            chk("roundtrip", rec, rnd);
            if (lat != 5) chk("roundtrip_latency", 128'(lat), 128'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward-direction (encryption) MixColumns engine, the counterpart of the decryption-side InvMixColumns helper.
- Takes a 128-bit AES state over a valid/ready handshake, processes one 32-bit column per clock, and returns the mixed state over a valid/ready handshake with back-pressure.
- Sits in the encryption round datapath between ShiftRows and AddRoundKey.
- Has a per-transfer bypass for the final AES round, which omits MixColumns.

Parameters:
- NCOL, 4, number of columns per state; fixed by AES and not to be overridden; used only for counter sizing.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_bypass are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  128  state; column c = bits [127-32c -: 32]; byte 0 of a column at its MSB.
- in_bypass  input  1  1 = pass the state through unmixed (final round).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  mixed (or bypassed) state, same byte layout as in_data.
- busy  output  1  high while in BUSY.

Behaviour:
- Reset (async assert, sync release): state IDLE, col counter 0, data register 0. Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the work register.
  - If in_bypass=1, go to DONE; otherwise go to BUSY with col=0.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, replace column col of the work register with mix(column col), then col++.
  - When col==3, go to DONE after the update; col wraps to 0.
  - Exactly 4 BUSY cycles per state.
- DONE:
  - out_valid=1, out_data=work register, held stable until out_ready=1.
  - in_ready=out_ready, so a back-to-back transfer is allowed.
  - On out handshake with no new input: go to IDLE.
  - On out handshake with a simultaneous in handshake: latch the new state and go to BUSY (or stay in DONE if in_bypass=1). out_valid stays high only in the bypass case, with the new data.
- Latency, measured from the in-handshake edge to the first cycle out_valid=1:
  - 5 cycles when mixing (4 BUSY + 1).
  - 1 cycle when bypassing.
  - Throughput with out_ready held at 1 is one state per 5 cycles (mixing).
- Column math over GF(2^8), polynomial 0x11B, column bytes a0..a3 (a0 at MSB):
  - r0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - r1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - r2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - r3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x)^x.
  - Purely 8-bit; no lookup tables.
- in_valid while in BUSY is ignored; no data is accepted and nothing is corrupted. The upstream must hold its request.
- in_bypass is sampled only at the in handshake.
- Async reset mid-BUSY or mid-DONE discards the state in flight and returns to reset values immediately.
- out_data only changes on a column update or a load, never while out_valid=1 and out_ready=0.

Decomposition:
- aes_pkg holds:
  - constants AES_STATE_W=128, AES_COL_W=32, AES_POLY=8'h1B;
  - the xtime function;
  - the FSM state enum {IDLE, BUSY, DONE}.
- Sub-module mix_column_fwd: purely combinational, 32-bit in to 32-bit out, implementing r0..r3. It is the forward mirror of the inverse column helper. One instance is shared across the 4 BUSY cycles via a column mux.

Test Plan:
- FIPS-197 round 1: in_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5, bypass=0, out_ready=1 -> out_valid in cycle 5, out_data=046681e5_e0cb199a_48f8d37a_2806264c, busy high exactly 4 cycles.
- Known columns: in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6; second run with d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Bypass: in_data=00112233_44556677_8899aabb_ccddeeff, bypass=1 -> out_valid 1 cycle later, out_data identical to input.
- Back-pressure and back-to-back: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. Then raise out_ready together with a new in_valid -> old state leaves, new state is accepted the same cycle, and its correct result appears 5 cycles later.
- Reset mid-op: deassert rst_n asynchronously at BUSY col=2 -> out_valid=0, in_ready=1, out_data=0 immediately. After release, a fresh FIPS vector gives the correct result.
- Round-trip: 200 random states through mix_columns_seq, then the inverse column helper per column -> original state recovered. In_valid pulses randomly during BUSY are ignored.
